// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU operation sequencer: state and display-source encodings,
// the error display pattern and a load-state helper.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SHOW    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_ENTRY  = 2'd0,
        SEL_RESULT = 2'd1,
        SEL_ERROR  = 2'd2,
        SEL_BUSY   = 2'd3
    } disp_sel_e;

    // Every nibble shows 'E'; sliced down to the display width by the user.
    localparam logic [63:0] ERR_PATTERN = {16{4'hE}};

    function automatic logic is_load(input state_e s);
        return (s == ST_LOAD_A) || (s == ST_LOAD_B) || (s == ST_LOAD_OP);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_entry_shift.sv
// Bit-serial entry register: shifts one bit in from the LSB side, the MSB falls off.
// A synchronous zero request takes priority over a shift in the same cycle.
module entry_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shift_en,
    input  logic             bit_d,
    input  logic             zero,
    output logic [WIDTH-1:0] entry
);

    logic [WIDTH-1:0] entry_q;
    logic [WIDTH-1:0] entry_d;

    always_comb begin
        entry_d = entry_q;
        if (zero) begin
            entry_d = '0;
        end else if (shift_en) begin
            entry_d = {entry_q[WIDTH-2:0], bit_d};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation from button pulses: load A, B, opcode, launch, wait, show.
// Optional WAIT-state watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int NUM_OPS = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bit_en,
    input  logic             bit_d,
    input  logic             enter,
    input  logic             clear,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   op_code,
    output logic             alu_start,
    output logic [WIDTH-1:0] disp_val,
    output logic [1:0]       disp_sel,
    output logic             ovf,
    output logic             err,
    output logic [2:0]       state_o
);

    localparam logic [WIDTH-1:0] NUM_OPS_W = WIDTH'(NUM_OPS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [OPW-1:0]   op_code_q, op_code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] entry;
    logic             in_load;
    logic             tmo_hit;
    disp_sel_e        disp_sel_c;

    assign in_load = is_load(state_q);

    // Enter wins over a coincident bit pulse, so the committed entry restarts at zero.
    entry_shift #(.WIDTH(WIDTH)) u_entry (
        .clk      (clk),
        .rstn     (rstn),
        .shift_en (bit_en && in_load && !enter && !clear),
        .bit_d    (bit_d),
        .zero     (clear || (enter && in_load)),
        .entry    (entry)
    );

`ifdef ALU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        if (clear) begin
            state_d   = ST_LOAD_A;
            op_a_d    = '0;
            op_b_d    = '0;
            op_code_d = '0;
            result_d  = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: if (enter) begin
                    op_a_d  = entry;
                    state_d = ST_LOAD_B;
                end
                ST_LOAD_B: if (enter) begin
                    op_b_d  = entry;
                    state_d = ST_LOAD_OP;
                end
                ST_LOAD_OP: if (enter) begin
                    op_code_d = entry[OPW-1:0];
                    state_d   = (entry >= NUM_OPS_W) ? ST_ERROR : ST_EXEC;
                end
                ST_EXEC: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (alu_done) begin
                        result_d = alu_result;
                        ovf_d    = alu_ovf;
                        state_d  = ST_SHOW;
                    end else if (tmo_hit) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SHOW, ST_ERROR: if (enter) begin
                    state_d = ST_LOAD_A;
                end
                default: state_d = ST_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_LOAD_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        disp_val   = '0;
        disp_sel_c = SEL_ENTRY;
        case (state_q)
            ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: begin
                disp_val   = entry;
                disp_sel_c = SEL_ENTRY;
            end
            ST_EXEC, ST_WAIT: begin
                disp_val   = '0;
                disp_sel_c = SEL_BUSY;
            end
            ST_SHOW: begin
                disp_val   = result_q;
                disp_sel_c = SEL_RESULT;
            end
            ST_ERROR: begin
                disp_val   = ERR_PATTERN[WIDTH-1:0];
                disp_sel_c = SEL_ERROR;
            end
            default: begin
                disp_val   = '0;
                disp_sel_c = SEL_ENTRY;
            end
        endcase
    end

    assign disp_sel  = disp_sel_c;
    assign alu_start = (state_q == ST_EXEC);
    assign err       = (state_q == ST_ERROR);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_code   = op_code_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table, hand-written corner sequences and a
// randomized run against an arithmetic model of the entry/commit rules.
module tb_alu_op_sequencer;

    localparam int S_LOAD_A = 0, S_LOAD_B = 1, S_LOAD_OP = 2, S_EXEC = 3;
    localparam int S_WAIT = 4, S_SHOW = 5, S_ERROR = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bit_en = 1'b0, bit_d = 1'b0, enter = 1'b0, clear = 1'b0;
    logic        alu_done = 1'b0, alu_ovf = 1'b0;
    logic [15:0] alu_result = '0;
    logic [15:0] op_a, op_b, disp_val;
    logic [3:0]  op_code;
    logic        alu_start, ovf, err;
    logic [1:0]  disp_sel;
    logic [2:0]  state_o;

    int checks = 0;
    int failures = 0;

    alu_op_sequencer #(.WIDTH(16), .OPW(4), .NUM_OPS(8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bit_en     (bit_en),
        .bit_d      (bit_d),
        .enter      (enter),
        .clear      (clear),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_code    (op_code),
        .alu_start  (alu_start),
        .disp_val   (disp_val),
        .disp_sel   (disp_sel),
        .ovf        (ovf),
        .err        (err),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] op;
        int          opn;
        logic [15:0] res;
        logic        res_ovf;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bit_en = 1'b1;
        bit_d  = b;
        tick();
        bit_en = 1'b0;
        bit_d  = 1'b0;
    endtask

    task automatic shift_val(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] op, input int opn);
        shift_val({16'h0, a}, 16);
        press_enter();
        shift_val({16'h0, b}, 16);
        press_enter();
        shift_val(op, opn);
        press_enter();
    endtask

    task automatic alu_reply(input logic [15:0] res, input logic o);
        alu_done   = 1'b1;
        alu_result = res;
        alu_ovf    = o;
        tick();
        alu_done   = 1'b0;
        alu_ovf    = 1'b0;
    endtask

    // Model: the entry keeps the most recent 16 shifted bits, i.e. the value mod 2^16.
    task automatic shift_rand(input int n, output int val);
        int b;
        val = 0;
        for (int i = 0; i < n; i++) begin
            b = $urandom_range(0, 1);
            shift_bit(b[0]);
            val = (val * 2 + b) % 65536;
            if ($urandom_range(0, 5) == 0) tick();
        end
    endtask

    int          ma, mb, mop;
    logic [15:0] rres;
    logic        rovf;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0012, 16'h0034, 32'd3,    4, 16'h0046, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 16'hFFFF, 32'd7,    3, 16'h1233, 1'b1, 1'b0};
        vecs[2] = '{16'hAAAA, 16'h5555, 32'd8,    4, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{16'h0001, 16'h0002, 32'd9,    4, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0F0F, 32'h13,   5, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 32'd0,    1, 16'hBEEF, 1'b0, 1'b0};

        repeat (3) tick();
        check("reset_state", state_o, S_LOAD_A);
        check("reset_op_a", op_a, 0);
        check("reset_op_b", op_b, 0);
        check("reset_op_code", op_code, 0);
        check("reset_disp_sel", disp_sel, 0);
        check("reset_start", alu_start, 0);
        check("reset_err", err, 0);
        check("reset_ovf", ovf, 0);
        rstn = 1'b1;
        tick();
        check("post_reset_disp", disp_val, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].opn);
            check("vec_op_a", op_a, vecs[i].a);
            check("vec_op_b", op_b, vecs[i].b);
            check("vec_op_code", op_code, vecs[i].op[3:0]);
            if (vecs[i].exp_err) begin
                check("vec_err_state", state_o, S_ERROR);
                check("vec_err_flag", err, 1);
                check("vec_err_disp", disp_val, 16'hEEEE);
                check("vec_err_sel", disp_sel, 2);
                check("vec_err_start", alu_start, 0);
            end else begin
                check("vec_exec_state", state_o, S_EXEC);
                check("vec_start", alu_start, 1);
                tick();
                check("vec_wait_state", state_o, S_WAIT);
                check("vec_start_once", alu_start, 0);
                check("vec_busy_sel", disp_sel, 3);
                alu_reply(vecs[i].res, vecs[i].res_ovf);
                check("vec_show_state", state_o, S_SHOW);
                check("vec_disp", disp_val, vecs[i].res);
                check("vec_sel", disp_sel, 1);
                check("vec_ovf", ovf, vecs[i].res_ovf);
                check("vec_hold_op_a", op_a, vecs[i].a);
            end
            press_enter();
            check("vec_back_load_a", state_o, S_LOAD_A);
        end

        // enter and bit_en together: operand committed, bit dropped
        shift_val(32'h5, 3);
        enter = 1'b1; bit_en = 1'b1; bit_d = 1'b1;
        tick();
        enter = 1'b0; bit_en = 1'b0; bit_d = 1'b0;
        check("coinc_op_a", op_a, 16'h0005);
        check("coinc_state", state_o, S_LOAD_B);
        check("coinc_entry", disp_val, 0);
        shift_val(32'h2, 2);
        press_enter();
        shift_val(32'h1, 4);
        press_enter();
        tick();
        check("abort_in_wait", state_o, S_WAIT);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_state", state_o, S_LOAD_A);
        check("clear_op_a", op_a, 0);
        check("clear_op_b", op_b, 0);
        check("clear_op_code", op_code, 0);
        alu_reply(16'h1234, 1'b1);
        check("late_done_state", state_o, S_LOAD_A);
        check("late_done_disp", disp_val, 0);
        check("late_done_ovf", ovf, 0);

        // 17 ones: oldest bit falls off the top
        shift_val(32'h1FFFF, 17);
        check("overflow_entry", disp_val, 16'hFFFF);
        press_enter();
        check("overflow_op_a", op_a, 16'hFFFF);
        shift_val(32'h1, 1);
        press_enter();
        shift_val(32'h2, 2);
        press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("enter_in_exec_ignored", state_o, S_WAIT);
        alu_reply(16'h0042, 1'b0);
        shift_bit(1'b1);
        check("bit_in_show_state", state_o, S_SHOW);
        check("bit_in_show_disp", disp_val, 16'h0042);
        press_enter();
        check("after_show_entry", disp_val, 0);

        // WAIT-state watchdog: terminal count is the 4th WAIT cycle
        run_op(16'h1, 16'h2, 32'h1, 1);
        tick();
        repeat (3) tick();
        check("wait_4th_cycle", state_o, S_WAIT);
`ifdef ALU_TIMEOUT_EN
        tick();
        check("timeout_state", state_o, S_ERROR);
        check("timeout_err", err, 1);
        press_enter();
        check("timeout_recover", state_o, S_LOAD_A);
        run_op(16'h1, 16'h2, 32'h1, 1);
        tick();
        repeat (3) tick();
        alu_reply(16'h0003, 1'b0);
        check("done_on_terminal_state", state_o, S_SHOW);
        check("done_on_terminal_disp", disp_val, 16'h0003);
`else
        repeat (20) tick();
        check("no_timeout_state", state_o, S_WAIT);
        alu_reply(16'h0003, 1'b0);
        check("late_reply_state", state_o, S_SHOW);
        check("late_reply_disp", disp_val, 16'h0003);
`endif
        press_enter();

        for (int it = 0; it < 40; it++) begin
            shift_rand($urandom_range(1, 20), ma);
            press_enter();
            shift_rand($urandom_range(1, 20), mb);
            press_enter();
            shift_rand($urandom_range(1, 6), mop);
            press_enter();
            check("rnd_op_a", op_a, ma);
            check("rnd_op_b", op_b, mb);
            check("rnd_op_code", op_code, mop % 16);
            if (mop >= 8) begin
                check("rnd_err_state", state_o, S_ERROR);
                check("rnd_err_disp", disp_val, 16'hEEEE);
            end else begin
                check("rnd_start", alu_start, 1);
                tick();
                if ($urandom_range(0, 7) == 0) begin
                    clear = 1'b1;
                    tick();
                    clear = 1'b0;
                    check("rnd_clear_state", state_o, S_LOAD_A);
                    check("rnd_clear_op_a", op_a, 0);
                end else begin
                    rres = 16'($urandom());
                    rovf = 1'($urandom_range(0, 1));
                    alu_reply(rres, rovf);
                    check("rnd_disp", disp_val, rres);
                    check("rnd_ovf", ovf, rovf);
                    check("rnd_op_b_hold", op_b, mb);
                end
            end
            if (state_o != S_LOAD_A) press_enter();
            check("rnd_idle_state", state_o, S_LOAD_A);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control FSM that sequences one ALU operation from pushbutton-level inputs.
- Collects operand A, operand B and an opcode bit-serially from debounced single-cycle pulses.
- Issues a one-cycle start to the ALU, waits for done, then holds the result for display.
- Sits between the button edge-detect/shift logic and the ALU and seven-segment display path in the top level.

Parameters:
WIDTH, 16, operand/result width in bits.
OPW, 4, opcode width in bits.
NUM_OPS, 8, count of valid opcodes; opcodes >= NUM_OPS are illegal.
TIMEOUT, 255, WAIT-state cycle limit; used only with ALU_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
bit_en  in  1  single-cycle pulse: shift one bit into the entry register
bit_d  in  1  value of the bit shifted in when bit_en=1
enter  in  1  single-cycle pulse: commit the current entry or advance
clear  in  1  synchronous abort back to LOAD_A
alu_done  in  1  ALU result valid, sampled in WAIT only
alu_result  in  WIDTH  ALU result
alu_ovf  in  1  ALU overflow flag, captured with the result
op_a  out  WIDTH  registered operand A to the ALU
op_b  out  WIDTH  registered operand B to the ALU
op_code  out  OPW  registered opcode to the ALU
alu_start  out  1  one-cycle launch pulse
disp_val  out  WIDTH  value routed to the seven-segment decoders
disp_sel  out  2  display source: 0=entry, 1=result, 2=error, 3=busy
ovf  out  1  captured overflow flag, valid in SHOW
err  out  1  high while in ERROR
state_o  out  3  current state encoding, for debug LEDs

Behaviour:
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, WAIT, SHOW, ERROR.
- Reset: state=LOAD_A; entry, op_a, op_b, op_code, result, ovf all 0; alu_start=0; err=0.
- Entry register (WIDTH bits):
  - In LOAD_A, LOAD_B and LOAD_OP, bit_en shifts left: entry <= {entry[WIDTH-2:0], bit_d}. The MSB is discarded.
  - bit_en is ignored in all other states.
- Input priority each cycle: clear > enter > bit_en. If enter and bit_en coincide, the bit is discarded.
- clear, from any state: next state LOAD_A; entry, op_a, op_b, op_code, result and ovf zeroed. An in-flight ALU done is ignored.
- LOAD_A + enter: op_a <= entry; entry <= 0; next LOAD_B.
- LOAD_B + enter: op_b <= entry; entry <= 0; next LOAD_OP.
- LOAD_OP + enter: op_code <= entry[OPW-1:0]; entry <= 0.
  - If the full entry value >= NUM_OPS, next ERROR (upper non-zero bits also count as illegal).
  - Otherwise next EXEC.
- EXEC: alu_start=1 for exactly this one cycle; next WAIT unconditionally. enter is ignored.
- WAIT: on alu_done=1, result <= alu_result, ovf <= alu_ovf, next SHOW. enter is ignored. alu_done in any other state is ignored.
- SHOW: holds result. enter -> LOAD_A. op_a, op_b and op_code keep their values until overwritten by the next commit.
- ERROR: err=1. enter -> LOAD_A.
- Latency: enter in LOAD_OP at cycle N gives alu_start high at N+1. alu_done at cycle M gives disp_val=result at M+1.
- disp_val and disp_sel (registered state, combinational mux):
  - LOAD_*: entry, sel 0.
  - EXEC/WAIT: 0, sel 3.
  - SHOW: result, sel 1.
  - ERROR: all bits set to the 4'hE pattern, sel 2.
- op_a, op_b and op_code are stable from EXEC through the end of WAIT.

Optional Feature:
ALU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter (width $clog2(TIMEOUT+1)) clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT with no alu_done, next state is ERROR.
  - If alu_done arrives in the same cycle as the terminal count, done wins and the next state is SHOW.
- Undefined: no counter; WAIT persists until alu_done or clear.

Decomposition:
- Package alu_ctrl_pkg: state enum (3-bit), disp_sel enum, ERR_PATTERN constant (all-E nibble pattern).
- Sub-module entry_shift:
  - Contains the WIDTH-bit entry register with shift-enable, synchronous zero and asynchronous reset.
  - Instantiated once.

Test Plan:
1. Reset → state=LOAD_A, op_a/op_b/op_code=0, disp_sel=0, alu_start=0.
2. Shift in 0x0012 + enter, 0x0034 + enter, op 3 + enter → op_a=0x0012, op_b=0x0034, op_code=3, one-cycle alu_start. Then alu_done with result 0x0046 → disp_val=0x0046, sel=1.
3. Opcode entry 9 with NUM_OPS=8, then enter → ERROR, err=1, disp_val=0xEEEE. Then enter → LOAD_A.
4. enter and bit_en in the same cycle in LOAD_A → op_a captured, bit not shifted into the new entry (entry=0). clear asserted in WAIT → LOAD_A, all operands 0, a later alu_done ignored.
5. 17 bit_en pulses with bit_d=1 → entry=0xFFFF (MSB overflow discarded). bit_en in SHOW → no change.
6. ALU_TIMEOUT_EN, TIMEOUT=4:
   - No done → ERROR after 4 WAIT cycles.
   - alu_done on the terminal cycle → SHOW.
